// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Purpose  : Shared widths, the store-buffer entry type and the youngest-match
//            helper for the CPU memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

   localparam int c_DEF_DW    = 16;  // default data word width
   localparam int c_DEF_AW    = 8;   // default address width
   localparam int c_MAX_DEPTH = 64;  // largest store-buffer depth the helper covers
   localparam int c_IDX_W     = 6;   // index width able to address c_MAX_DEPTH entries

   typedef struct packed {
      logic [c_DEF_AW-1:0] addr;
      logic [c_DEF_DW-1:0] data;
   } sb_entry_t;

   // Walks the circular FIFO from the head (oldest) towards the tail and keeps
   // the last matching slot, so the result is the youngest matching entry.
   // depth must be a power of two; it is constant at every call site so the
   // loop collapses to a fixed priority mux.
   function automatic logic [c_IDX_W-1:0] youngest_match(
      input logic [c_MAX_DEPTH-1:0] hit,
      input logic [c_IDX_W-1:0]     head,
      input int                     depth
   );
      logic [c_IDX_W-1:0] sel;
      logic [c_IDX_W-1:0] idx;
      logic [c_IDX_W-1:0] msk;
      sel = head;
      msk = c_IDX_W'(depth - 1);
      for (int k = 0; k < c_MAX_DEPTH; k++) begin
         if (k < depth) begin
            idx = (head + c_IDX_W'(k)) & msk;
            if (hit[idx]) sel = idx;
         end
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_buffer
// Purpose  : Circular store FIFO with occupancy count and two parallel
//            address-match lookups (fetch side and data side) that return the
//            youngest matching entry.
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_buffer
   import cpu_mem_pkg::*;
#(
   parameter int DW    = c_DEF_DW,
   parameter int AW    = c_DEF_AW,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [AW-1:0]            push_addr,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [AW-1:0]            head_addr,
   output logic [DW-1:0]            head_data,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [AW-1:0]            fa_addr,
   output logic                     fa_hit,
   output logic [DW-1:0]            fa_data,
   input  logic [AW-1:0]            da_addr,
   output logic                     da_hit,
   output logic [DW-1:0]            da_data
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;

   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;

   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_fhit;
   logic [DEPTH-1:0] w_dhit;
   logic [c_PW-1:0]  w_fsel;
   logic [c_PW-1:0]  w_dsel;

   // An entry is live when its distance from the head is below the count;
   // the head itself stays live during the cycle it drains.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [c_PW-1:0] w_age;
      assign w_age      = c_PW'(i) - r_rd_ptr;
      assign w_valid[i] = ({1'b0, w_age} < r_count);
      assign w_fhit[i]  = w_valid[i] & (r_addr[i] == fa_addr);
      assign w_dhit[i]  = w_valid[i] & (r_addr[i] == da_addr);
   end

   assign w_fsel = c_PW'(youngest_match(c_MAX_DEPTH'(w_fhit), c_IDX_W'(r_rd_ptr), DEPTH));
   assign w_dsel = c_PW'(youngest_match(c_MAX_DEPTH'(w_dhit), c_IDX_W'(r_rd_ptr), DEPTH));

   assign fa_hit    = |w_fhit;
   assign fa_data   = r_data[w_fsel];
   assign da_hit    = |w_dhit;
   assign da_data   = r_data[w_dsel];
   assign head_addr = r_addr[r_rd_ptr];
   assign head_data = r_data[r_rd_ptr];
   assign count     = r_count;

   // Entry payload storage; contents are meaningless until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         r_addr[r_wr_ptr] <= push_addr;
         r_data[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
         if (push && !pop)      r_count <= r_count + c_CW'(1);
         else if (!push && pop) r_count <= r_count - c_CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder: fetch read port, shared data read/write
//            port, store buffer draining into the array when the data port is
//            idle, and fixed-latency read pipelines that snoop the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int DW    = c_DEF_DW,
   parameter int AW    = c_DEF_AW,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     if_valid,
   input  logic [AW-1:0]            if_addr,
   output logic                     if_rvalid,
   output logic [DW-1:0]            if_rdata,
   input  logic                     dr_valid,
   output logic                     dr_ready,
   input  logic [AW-1:0]            dr_addr,
   output logic                     dr_rvalid,
   output logic [DW-1:0]            dr_rdata,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DW-1:0]            wr_data,
   output logic [$clog2(DEPTH):0]   sb_count,
   output logic                     sb_empty
);

   localparam int c_CW    = $clog2(DEPTH) + 1;
   localparam int c_WORDS = 2 ** AW;

   logic [DW-1:0]   r_mem [c_WORDS];

   logic            w_push;
   logic            w_full;
   logic            w_dr_acc;
   logic            w_drain;
   logic [AW-1:0]   w_head_addr;
   logic [DW-1:0]   w_head_data;
   logic [c_CW-1:0] w_count;
   logic            w_fa_hit;
   logic [DW-1:0]   w_fa_data;
   logic            w_da_hit;
   logic [DW-1:0]   w_da_data;

   logic [1:0]      w_req;
   logic [DW-1:0]   w_res     [2];
   logic [1:0]      w_rvalid;
   logic [DW-1:0]   w_rdata   [2];

   // Arbitration: a full buffer steals the data port for one forced drain.
   assign w_full   = (w_count == c_CW'(DEPTH));
   assign wr_ready = ~w_full;
   assign dr_ready = ~w_full;
   assign w_push   = wr_valid & wr_ready;
   assign w_dr_acc = dr_valid & dr_ready;
   assign w_drain  = (w_count != '0) & ~w_dr_acc;
   assign sb_count = w_count;
   assign sb_empty = (w_count == '0);

   mem_store_buffer #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (w_drain),
      .head_addr (w_head_addr),
      .head_data (w_head_data),
      .count     (w_count),
      .fa_addr   (if_addr),
      .fa_hit    (w_fa_hit),
      .fa_data   (w_fa_data),
      .da_addr   (dr_addr),
      .da_hit    (w_da_hit),
      .da_data   (w_da_data)
   );

   // Array write port: the head of the store buffer lands here on drain.
   always_ff @(posedge clk) begin
      if (w_drain) r_mem[w_head_addr] <= w_head_data;
   end

   // Read resolution in the request cycle: same-cycle store first, then the
   // youngest buffered store, then the array word.
   always_comb begin
      w_res[0] = r_mem[if_addr];
      w_res[1] = r_mem[dr_addr];
      if (w_push && (wr_addr == if_addr)) w_res[0] = wr_data;
      else if (w_fa_hit)                  w_res[0] = w_fa_data;
      if (w_push && (wr_addr == dr_addr)) w_res[1] = wr_data;
      else if (w_da_hit)                  w_res[1] = w_da_data;
   end

   assign w_req[0] = if_valid;
   assign w_req[1] = w_dr_acc;

   // Lane 0 is fetch, lane 1 is data; each is LAT registers deep so a request
   // presented in cycle T is visible in cycle T+LAT.
   for (genvar p = 0; p < 2; p++) begin : g_pipe
      logic [LAT-1:0] r_v;
      logic [DW-1:0]  r_d [LAT];

      // Shift the resolved value and its valid down the latency line.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v <= '0;
            for (int i = 0; i < LAT; i++) r_d[i] <= '0;
         end else begin
            r_v[0] <= w_req[p];
            r_d[0] <= w_res[p];
            for (int i = 1; i < LAT; i++) begin
               r_v[i] <= r_v[i-1];
               r_d[i] <= r_d[i-1];
            end
         end
      end

      assign w_rvalid[p] = r_v[LAT-1];
      assign w_rdata[p]  = r_d[LAT-1];
   end

   assign if_rvalid = w_rvalid[0];
   assign if_rdata  = w_rdata[0];
   assign dr_rvalid = w_rvalid[1];
   assign dr_rdata  = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_responder;
   import cpu_mem_pkg::*;

   localparam int c_DW    = 16;
   localparam int c_AW    = 8;
   localparam int c_LAT   = 2;
   localparam int c_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_valid;
   logic [c_AW-1:0]   if_addr;
   logic              if_rvalid;
   logic [c_DW-1:0]   if_rdata;
   logic              dr_valid;
   logic              dr_ready;
   logic [c_AW-1:0]   dr_addr;
   logic              dr_rvalid;
   logic [c_DW-1:0]   dr_rdata;
   logic              wr_valid;
   logic              wr_ready;
   logic [c_AW-1:0]   wr_addr;
   logic [c_DW-1:0]   wr_data;
   logic [2:0]        sb_count;
   logic              sb_empty;

   int n_vec = 0;
   int n_err = 0;

   sb_entry_t st [4];

   mem_responder #(
      .DW    (c_DW),
      .AW    (c_AW),
      .LAT   (c_LAT),
      .DEPTH (c_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_valid  (if_valid),
      .if_addr   (if_addr),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dr_valid  (dr_valid),
      .dr_ready  (dr_ready),
      .dr_addr   (dr_addr),
      .dr_rvalid (dr_rvalid),
      .dr_rdata  (dr_rdata),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .sb_count  (sb_count),
      .sb_empty  (sb_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_addr  = '0;
      dr_valid = 1'b0;
      dr_addr  = '0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      st[0] = '{addr: 8'h50, data: 16'hA000};
      st[1] = '{addr: 8'h51, data: 16'hA001};
      st[2] = '{addr: 8'h52, data: 16'hA002};
      st[3] = '{addr: 8'h53, data: 16'hA003};

      // Reset state
      repeat (2) tick();
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_dr_rvalid", 32'(dr_rvalid), 32'd0);
      chk("rst_if_rdata",  32'(if_rdata),  32'h0);
      chk("rst_dr_rdata",  32'(dr_rdata),  32'h0);
      chk("rst_sb_count",  32'(sb_count),  32'd0);
      chk("rst_sb_empty",  32'(sb_empty),  32'd1);
      chk("rst_wr_ready",  32'(wr_ready),  32'd1);
      chk("rst_dr_ready",  32'(dr_ready),  32'd1);
      rst_n = 1'b1;
      tick();

      // Preload array through the store path, then reset (array survives)
      store(8'h05, 16'h1234);
      store(8'h40, 16'h5A5A);
      tick();
      chk("pre_drained", 32'(sb_empty), 32'd1);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();

      // 1: fetch from array, latency 2
      if_valid = 1'b1;
      if_addr  = 8'h05;
      tick();
      if_valid = 1'b0;
      chk("t1_not_early", 32'(if_rvalid), 32'd0);
      tick();
      chk("t1_rvalid", 32'(if_rvalid), 32'd1);
      chk("t1_rdata",  32'(if_rdata),  32'h1234);
      tick();
      chk("t1_rvalid_drop", 32'(if_rvalid), 32'd0);

      // 2: write-first on same-cycle store and data read
      wr_valid = 1'b1;
      wr_addr  = 8'h10;
      wr_data  = 16'hBEEF;
      dr_valid = 1'b1;
      dr_addr  = 8'h10;
      chk("t2_dr_ready", 32'(dr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      dr_valid = 1'b0;
      tick();
      chk("t2_dr_rvalid", 32'(dr_rvalid), 32'd1);
      chk("t2_dr_rdata",  32'(dr_rdata),  32'hBEEF);
      chk("t2_empty",     32'(sb_empty),  32'd1);

      // 3: fill buffer while data port busy, then forced drain
      dr_valid = 1'b1;
      dr_addr  = 8'h77;
      for (int i = 0; i < 4; i++) store(st[i].addr, st[i].data);
      chk("t3_count_full", 32'(sb_count), 32'd4);
      chk("t3_wr_ready0",  32'(wr_ready), 32'd0);
      chk("t3_dr_ready0",  32'(dr_ready), 32'd0);
      tick();
      chk("t3_count_3",    32'(sb_count), 32'd3);
      chk("t3_wr_ready1",  32'(wr_ready), 32'd1);
      chk("t3_dr_ready1",  32'(dr_ready), 32'd1);
      tick();
      chk("t3_hold_busy",  32'(sb_count), 32'd3);
      dr_valid = 1'b0;
      repeat (3) tick();
      chk("t3_drained",    32'(sb_empty), 32'd1);
      if_valid = 1'b1;
      if_addr  = 8'h53;
      tick();
      if_valid = 1'b0;
      tick();
      chk("t3_array_53",   32'(if_rdata), 32'hA003);

      // 4: duplicate addresses, youngest wins, even while head drains
      dr_valid = 1'b1;
      dr_addr  = 8'h99;
      store(8'h20, 16'h1111);
      store(8'h20, 16'h2222);
      dr_addr  = 8'h20;
      tick();
      dr_valid = 1'b0;
      if_valid = 1'b1;
      if_addr  = 8'h20;
      tick();
      if_valid = 1'b0;
      chk("t4_dr_rvalid",  32'(dr_rvalid), 32'd1);
      chk("t4_dr_rdata",   32'(dr_rdata),  32'h2222);
      tick();
      chk("t4_if_draining", 32'(if_rdata), 32'h2222);
      chk("t4_empty",      32'(sb_empty),  32'd1);
      if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
      tick();
      chk("t4_array_20",   32'(if_rdata),  32'h2222);

      // 5: fetch snoops an undrained store
      dr_valid = 1'b1;
      dr_addr  = 8'h99;
      store(8'h30, 16'h00AB);
      if_valid = 1'b1;
      if_addr  = 8'h30;
      tick();
      if_valid = 1'b0;
      chk("t5_count", 32'(sb_count), 32'd1);
      tick();
      chk("t5_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("t5_if_rdata",  32'(if_rdata),  32'h00AB);
      dr_valid = 1'b0;
      tick();
      chk("t5_empty", 32'(sb_empty), 32'd1);

      // 6: reset with reads in flight and stores buffered
      dr_valid = 1'b1;
      dr_addr  = 8'h99;
      store(8'h60, 16'hC000);
      store(8'h61, 16'hC001);
      store(8'h62, 16'hC002);
      if_valid = 1'b1;
      if_addr  = 8'h05;
      dr_addr  = 8'h40;
      tick();
      if_valid = 1'b0;
      dr_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("t6_rst_empty", 32'(sb_empty), 32'd1);
      chk("t6_rst_count", 32'(sb_count), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_rvalid", 32'({if_rvalid, dr_rvalid}), 32'd0);
      end
      chk("t6_empty_after", 32'(sb_empty), 32'd1);
      if_valid = 1'b1;
      if_addr  = 8'h05;
      dr_valid = 1'b1;
      dr_addr  = 8'h40;
      tick();
      if_valid = 1'b0;
      dr_valid = 1'b0;
      tick();
      chk("t6_if_rdata", 32'(if_rdata), 32'h1234);
      chk("t6_dr_rdata", 32'(dr_rdata), 32'h5A5A);
      chk("t6_rvalids",  32'({if_rvalid, dr_rvalid}), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
